// File: rtl/axi_lite_ram_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite RAM controller.
package axi_lite_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

endpackage

// File: rtl/axi_lite_ram_ctrl_if.sv
// AXI4-Lite slave-side bus bundle; the controller uses the slave modport.
interface axi_lite_ram_ctrl_if #(
    parameter int AXI_ADDR_W       = 32,
    parameter int DATA_WIDTH_BYTES = 4
);
    logic [AXI_ADDR_W-1:0]         s_awaddr;
    logic                          s_awvalid;
    logic                          s_awready;
    logic [8*DATA_WIDTH_BYTES-1:0] s_wdata;
    logic [DATA_WIDTH_BYTES-1:0]   s_wstrb;
    logic                          s_wvalid;
    logic                          s_wready;
    logic [1:0]                    s_bresp;
    logic                          s_bvalid;
    logic                          s_bready;
    logic [AXI_ADDR_W-1:0]         s_araddr;
    logic                          s_arvalid;
    logic                          s_arready;
    logic [8*DATA_WIDTH_BYTES-1:0] s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rvalid;
    logic                          s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axi_lite_slot_decode.sv
// Byte address to RAM slot index, flagging addresses that fall outside the RAM.
module axi_lite_slot_decode
    import axi_lite_ram_pkg::*;
#(
    parameter int NUM_SLOTS        = 6,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int AXI_ADDR_W       = 32,
    parameter int SLOT_W           = $clog2(NUM_SLOTS),
    parameter int LSB_W            = $clog2(DATA_WIDTH_BYTES)
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    output logic [SLOT_W-1:0]     slot,
    output logic                  in_range
);
    // Byte-offset bits are deliberately ignored: misaligned accesses act aligned.
    logic unused_lsb;
    assign unused_lsb = ^addr[LSB_W-1:0];

    always_comb begin
        slot     = addr[LSB_W +: SLOT_W];
        in_range = (addr[AXI_ADDR_W-1:LSB_W+SLOT_W] == '0) && (32'(slot) < NUM_SLOTS);
    end
endmodule

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave sequencing a byte-strobed RAM with concurrent read/write FSMs.
module axi_lite_ram_ctrl
    import axi_lite_ram_pkg::*;
#(
    parameter int NUM_SLOTS        = 6,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int AXI_ADDR_W       = 32,
    parameter int SLOT_W           = $clog2(NUM_SLOTS),
    parameter int LSB_W            = $clog2(DATA_WIDTH_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_lite_ram_ctrl_if.slave            bus,
    output logic                          ram_w_en,
    output logic [SLOT_W-1:0]             ram_w_addr,
    output logic [8*DATA_WIDTH_BYTES-1:0] ram_w_data,
    output logic [DATA_WIDTH_BYTES-1:0]   ram_w_strb,
    output logic                          ram_r_en,
    output logic [SLOT_W-1:0]             ram_r_addr,
    input  logic [8*DATA_WIDTH_BYTES-1:0] ram_r_data
);
    localparam int DATA_W = 8 * DATA_WIDTH_BYTES;

    w_state_e                    w_state;
    logic                        aw_held, w_held;
    logic [AXI_ADDR_W-1:0]       awaddr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [DATA_WIDTH_BYTES-1:0] wstrb_q;
    logic                        awready_q, wready_q, bvalid_q;
    logic [1:0]                  bresp_q;
    logic [SLOT_W-1:0]           w_slot;
    logic                        w_in_range;
    logic                        aw_hs, w_hs;

    r_state_e                    r_state;
    logic [AXI_ADDR_W-1:0]       araddr_q;
    logic                        arready_q, rvalid_q;
    logic [DATA_W-1:0]           rdata_q;
    logic [1:0]                  rresp_q;
    logic [SLOT_W-1:0]           r_slot;
    logic                        r_in_range;
    logic                        ar_hs, hazard;

    axi_lite_slot_decode #(
        .NUM_SLOTS(NUM_SLOTS), .DATA_WIDTH_BYTES(DATA_WIDTH_BYTES), .AXI_ADDR_W(AXI_ADDR_W),
        .SLOT_W(SLOT_W), .LSB_W(LSB_W)
    ) u_aw_decode (.addr(awaddr_q), .slot(w_slot), .in_range(w_in_range));

    axi_lite_slot_decode #(
        .NUM_SLOTS(NUM_SLOTS), .DATA_WIDTH_BYTES(DATA_WIDTH_BYTES), .AXI_ADDR_W(AXI_ADDR_W),
        .SLOT_W(SLOT_W), .LSB_W(LSB_W)
    ) u_ar_decode (.addr(araddr_q), .slot(r_slot), .in_range(r_in_range));

    assign aw_hs = bus.s_awvalid && awready_q;
    assign w_hs  = bus.s_wvalid && wready_q;
    assign ar_hs = bus.s_arvalid && arready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= bus.s_awaddr;
                        aw_held  <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= bus.s_wdata;
                        wstrb_q <= bus.s_wstrb;
                        w_held  <= 1'b1;
                    end
                    awready_q <= !aw_held && !aw_hs;
                    wready_q  <= !w_held && !w_hs;
                    if ((aw_held || aw_hs) && (w_held || w_hs))
                        w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    bresp_q  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
                    bvalid_q <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (bus.s_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign ram_w_en   = (w_state == W_COMMIT) && w_in_range;
    assign ram_w_addr = w_slot;
    assign ram_w_data = wdata_q;
    assign ram_w_strb = wstrb_q;

    // RAM reads are combinational, so a same-slot commit this cycle would be missed.
    assign hazard = ram_w_en && (w_slot == r_slot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        araddr_q <= bus.s_araddr;
                        r_state  <= R_READ;
                    end
                end
                R_READ: begin
                    if (!hazard) begin
                        rdata_q  <= r_in_range ? ram_r_data : '0;
                        rresp_q  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q <= 1'b1;
                        r_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.s_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign ram_r_en   = (r_state == R_READ);
    assign ram_r_addr = r_slot;

    assign bus.s_awready = awready_q;
    assign bus.s_wready  = wready_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = bresp_q;
    assign bus.s_arready = arready_q;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = rresp_q;
endmodule
